// File: rtl/wb_stage.sv
// Writeback stage: registers MEM results, formats load data, selects the regfile
// write value, and owns the tohost CSR plus the cycle/instret counters.
module wb_stage #(
    parameter logic [31:0] NOP_INST    = 32'h0000_0013,
    parameter logic [3:0]  IO_ADDR_TOP = 4'b1000,
    parameter logic [11:0] CSR_TOHOST  = 12'h51E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stall,
    input  logic        wb_flush,
    input  logic [31:0] mem_pc4,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_inst,
    input  logic [31:0] mem_dmem_dout,
    input  logic [31:0] mem_io_dout,
    input  logic        cnt_clear,
    output logic [31:0] wb_inst,
    output logic [31:0] wb_wdata,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] csr_tohost,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0] r_pc4, r_alu, r_inst;
    logic [31:0] r_tohost, r_cycle, r_instret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc4  <= '0;
            r_alu  <= '0;
            r_inst <= NOP_INST;
        end else if (wb_flush) begin
            r_pc4  <= '0;
            r_alu  <= '0;
            r_inst <= NOP_INST;
        end else if (!wb_stall) begin
            r_pc4  <= mem_pc4;
            r_alu  <= mem_alu;
            r_inst <= mem_inst;
        end
    end

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic [1:0]  w_off;
    logic [31:0] w_ld_src;
    logic [7:0]  w_bytes [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;
    logic        w_is_tohost;

    assign w_opcode = r_inst[6:0];
    assign w_funct3 = r_inst[14:12];
    assign w_rd     = r_inst[11:7];
    assign w_off    = r_alu[1:0];
    // BRAM/IO data arrives one cycle after MEM, so it is consumed unregistered here.
    assign w_ld_src = (r_alu[31:28] == IO_ADDR_TOP) ? mem_io_dout : mem_dmem_dout;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign w_bytes[gi] = w_ld_src[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_bytes[w_off];
    assign w_half = w_off[1] ? w_ld_src[31:16] : w_ld_src[15:0];

    always_comb begin
        w_ld_data = '0;
        case (w_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'b0, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'b0, w_half};
            3'b010:  w_ld_data = w_ld_src;
            default: w_ld_data = '0;
        endcase
    end

    assign w_is_tohost = (w_opcode == OP_SYSTEM) && (r_inst[31:20] == CSR_TOHOST) &&
                         ((w_funct3 == 3'b001) || (w_funct3 == 3'b101));

    logic        w_we_raw;
    logic [31:0] w_wdata;

    always_comb begin
        w_wdata  = r_alu;
        w_we_raw = 1'b0;
        case (w_opcode)
            OP_LOAD: begin
                w_wdata  = w_ld_data;
                w_we_raw = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                w_wdata  = r_pc4;
                w_we_raw = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_OP, OP_OPIMM: begin
                w_wdata  = r_alu;
                w_we_raw = 1'b1;
            end
            OP_SYSTEM: begin
                if (w_is_tohost) begin
                    w_wdata  = r_tohost;
                    w_we_raw = 1'b1;
                end
            end
            default: begin
                w_wdata  = r_alu;
                w_we_raw = 1'b0;
            end
        endcase
    end

    // The instruction in WB retires on this edge even when a flush replaces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tohost <= '0;
        end else if (!wb_stall && w_is_tohost) begin
            r_tohost <= (w_funct3 == 3'b001) ? r_alu : {27'b0, r_inst[19:15]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cycle <= cnt_clear ? '0 : r_cycle + 32'd1;
            if (cnt_clear)
                r_instret <= '0;
            else if (!wb_stall && (r_inst != NOP_INST))
                r_instret <= r_instret + 32'd1;
        end
    end

    assign wb_inst     = r_inst;
    assign wb_wdata    = w_wdata;
    assign wb_rd       = w_rd;
    assign wb_we       = w_we_raw && (w_rd != 5'd0);
    assign csr_tohost  = r_tohost;
    assign cycle_cnt   = r_cycle;
    assign instret_cnt = r_instret;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic checked against a
// behavioural model of the writeback rules.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_stall, wb_flush, cnt_clear;
    logic [31:0] mem_pc4, mem_alu, mem_inst, mem_dmem_dout, mem_io_dout;
    logic [31:0] wb_inst, wb_wdata, csr_tohost, cycle_cnt, instret_cnt;
    logic [4:0]  wb_rd;
    logic        wb_we;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    wb_stage dut (
        .clk(clk), .rst(rst), .wb_stall(wb_stall), .wb_flush(wb_flush),
        .mem_pc4(mem_pc4), .mem_alu(mem_alu), .mem_inst(mem_inst),
        .mem_dmem_dout(mem_dmem_dout), .mem_io_dout(mem_io_dout),
        .wb_inst(wb_inst), .wb_wdata(wb_wdata), .wb_rd(wb_rd), .wb_we(wb_we),
        .csr_tohost(csr_tohost), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
        .cnt_clear(cnt_clear)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Reference state: what sits in WB and the architectural counters
    logic [31:0] m_pc4, m_alu, m_inst, m_csr, m_cyc, m_ret;
    logic [31:0] cur_dmem, cur_io;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, n_cyc);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b & 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd4: return b;
            3'd1: return (h & 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd5: return h;
            3'd2: return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic is_tohost_csr(input logic [31:0] inst);
        return inst[6:0] == 7'h73 && inst[31:20] == 12'h51E &&
               (inst[14:12] == 3'd1 || inst[14:12] == 3'd5);
    endfunction

    task automatic model_reset();
        m_pc4 = 0; m_alu = 0; m_inst = NOP; m_csr = 0; m_cyc = 0; m_ret = 0;
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic cl,
                              input logic [31:0] pc4, input logic [31:0] alu,
                              input logic [31:0] inst);
        if (!st && is_tohost_csr(m_inst))
            m_csr = (m_inst[14:12] == 3'd1) ? m_alu : 32'(m_inst[19:15]);
        m_cyc = cl ? 32'h0 : m_cyc + 1;
        if (cl) m_ret = 0;
        else if (!st && m_inst != NOP) m_ret = m_ret + 1;
        if (fl) begin
            m_pc4 = 0; m_alu = 0; m_inst = NOP;
        end else if (!st) begin
            m_pc4 = pc4; m_alu = alu; m_inst = inst;
        end
    endtask

    task automatic check_all();
        logic [31:0] wd, src;
        logic        we;
        src = (m_alu[31:28] == 4'h8) ? cur_io : cur_dmem;
        wd = m_alu;
        we = 1'b0;
        case (m_inst[6:0])
            7'h03: begin wd = exp_load(src, m_inst[14:12], m_alu[1:0]); we = 1; end
            7'h6F, 7'h67: begin wd = m_pc4; we = 1; end
            7'h37, 7'h17, 7'h33, 7'h13: begin wd = m_alu; we = 1; end
            7'h73: if (is_tohost_csr(m_inst)) begin wd = m_csr; we = 1; end
            default: ;
        endcase
        if (m_inst[11:7] == 5'd0) we = 1'b0;
        check32("wb_inst", wb_inst, m_inst);
        check32("wb_wdata", wb_wdata, wd);
        check32("wb_rd", 32'(wb_rd), 32'(m_inst[11:7]));
        check32("wb_we", 32'(wb_we), 32'(we));
        check32("csr_tohost", csr_tohost, m_csr);
        check32("cycle_cnt", cycle_cnt, m_cyc);
        check32("instret_cnt", instret_cnt, m_ret);
        $display("cyc %0d inst=%08h wdata=%08h rd=%0d we=%0b tohost=%08h cyc_cnt=%0d ret=%0d",
                 n_cyc, wb_inst, wb_wdata, wb_rd, wb_we, csr_tohost, cycle_cnt, instret_cnt);
    endtask

    // One edge: drive MEM-side inputs, clock, then present read data for the new WB instr.
    task automatic run_cycle(input logic st, input logic fl, input logic cl,
                             input logic [31:0] pc4, input logic [31:0] alu,
                             input logic [31:0] inst, input logic [31:0] dm,
                             input logic [31:0] io);
        wb_stall = st; wb_flush = fl; cnt_clear = cl;
        mem_pc4 = pc4; mem_alu = alu; mem_inst = inst;
        @(posedge clk);
        n_cyc++;
        model_edge(st, fl, cl, pc4, alu, inst);
        #1;
        mem_dmem_dout = dm; mem_io_dout = io;
        cur_dmem = dm; cur_io = io;
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 13);
        case (k)
            0, 1: r[6:0] = 7'h03;
            2: r[6:0] = 7'h23;
            3: r[6:0] = 7'h63;
            4: r[6:0] = 7'h6F;
            5: r[6:0] = 7'h67;
            6: r[6:0] = 7'h37;
            7: r[6:0] = 7'h17;
            8: r[6:0] = 7'h33;
            9: r[6:0] = 7'h13;
            10: begin
                r[6:0] = 7'h73; r[31:20] = 12'h51E;
                r[14:12] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) :
                           (($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5);
            end
            11: r[6:0] = 7'h73;
            12: r = NOP;
            default: ;
        endcase
        return r;
    endfunction

    localparam logic [31:0] LB_X5    = {12'h0, 5'd1, 3'b000, 5'd5, 7'h03};
    localparam logic [31:0] LBU_X5   = {12'h0, 5'd1, 3'b100, 5'd5, 7'h03};
    localparam logic [31:0] LH_X5    = {12'h0, 5'd1, 3'b001, 5'd5, 7'h03};
    localparam logic [31:0] LW_X5    = {12'h0, 5'd1, 3'b010, 5'd5, 7'h03};
    localparam logic [31:0] JAL_X1   = 32'h0000_00EF;
    localparam logic [31:0] ADDI_X0  = 32'h0010_0013;
    localparam logic [31:0] SW       = 32'h0051_2023;
    localparam logic [31:0] ADD_X5   = 32'h0020_82B3;
    localparam logic [31:0] CSRWI_5  = {12'h51E, 5'd5, 3'b101, 5'd0, 7'h73};
    localparam logic [31:0] CSRWI_7  = {12'h51E, 5'd7, 3'b101, 5'd0, 7'h73};
    localparam logic [31:0] CSRW_X5  = {12'h51E, 5'd5, 3'b001, 5'd0, 7'h73};
    localparam logic [31:0] CSRRW_X3 = {12'h51E, 5'd5, 3'b001, 5'd3, 7'h73};

    initial begin
        logic [31:0] c0, r0;
        rst = 1'b1; wb_stall = 0; wb_flush = 0; cnt_clear = 0;
        mem_pc4 = 0; mem_alu = 0; mem_inst = NOP; mem_dmem_dout = 0; mem_io_dout = 0;
        cur_dmem = 0; cur_io = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Load alignment / source selection
        run_cycle(0, 0, 0, 32'h4, 32'h1000_0003, LB_X5, 32'h80FF_7F01, 32'h0);
        check32("lb_off3", wb_wdata, 32'hFFFF_FF80);
        run_cycle(0, 0, 0, 32'h8, 32'h1000_0001, LBU_X5, 32'h80FF_7F01, 32'h0);
        check32("lbu_off1", wb_wdata, 32'h0000_007F);
        run_cycle(0, 0, 0, 32'hC, 32'h1000_0002, LH_X5, 32'h80FF_7F01, 32'h0);
        check32("lh_off2", wb_wdata, 32'hFFFF_80FF);
        run_cycle(0, 0, 0, 32'h10, 32'h8000_0010, LW_X5, 32'hAAAA_AAAA, 32'h1234_5678);
        check32("lw_io", wb_wdata, 32'h1234_5678);

        // Writeback select and rd==0 gating
        run_cycle(0, 0, 0, 32'h2004, 32'h55, JAL_X1, 0, 0);
        check32("jal_we", 32'(wb_we), 32'd1);
        check32("jal_wdata", wb_wdata, 32'h2004);
        run_cycle(0, 0, 0, 0, 32'h1, ADDI_X0, 0, 0);
        check32("addi_x0_we", 32'(wb_we), 32'd0);
        run_cycle(0, 0, 0, 0, 32'h100, SW, 0, 0);
        check32("sw_we", 32'(wb_we), 32'd0);

        // tohost CSR
        run_cycle(0, 0, 0, 0, 32'h0, CSRWI_5, 0, 0);
        run_cycle(0, 0, 0, 0, 32'hDEAD_BEEF, CSRW_X5, 0, 0);
        check32("csrwi_5", csr_tohost, 32'h5);
        run_cycle(0, 0, 0, 0, 32'h0, CSRWI_7, 0, 0);
        check32("csrw_x5", csr_tohost, 32'hDEAD_BEEF);
        run_cycle(0, 0, 0, 0, 32'h99, CSRRW_X3, 0, 0);
        check32("csrrw_old", wb_wdata, 32'h7);
        run_cycle(0, 0, 0, 0, 0, NOP, 0, 0);
        check32("csrrw_new", csr_tohost, 32'h99);

        // Stall: one retire over four edges
        run_cycle(0, 0, 0, 0, 32'h42, ADD_X5, 0, 0);
        c0 = cycle_cnt; r0 = instret_cnt;
        repeat (3) run_cycle(1, 0, 0, 0, 0, NOP, 0, 0);
        run_cycle(0, 0, 0, 0, 0, NOP, 0, 0);
        check32("stall_cyc_delta", cycle_cnt - c0, 32'd4);
        check32("stall_ret_delta", instret_cnt - r0, 32'd1);

        // Flush wins over stall; next edge retires nothing
        run_cycle(0, 0, 0, 0, 32'h1, ADD_X5, 0, 0);
        run_cycle(1, 1, 0, 0, 32'h2, ADD_X5, 0, 0);
        check32("flush_inst", wb_inst, NOP);
        r0 = instret_cnt;
        run_cycle(0, 0, 0, 0, 0, NOP, 0, 0);
        check32("flush_no_ret", instret_cnt, r0);

        // Clear with a retiring instruction
        run_cycle(0, 0, 0, 0, 32'h3, ADD_X5, 0, 0);
        run_cycle(0, 0, 1, 0, 0, NOP, 0, 0);
        check32("clr_cycle", cycle_cnt, 32'h0);
        check32("clr_instret", instret_cnt, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[31:28] = 4'h8;
            run_cycle(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 29) == 0), $urandom, a, rand_inst(),
                      $urandom, $urandom);
        end

        // Asynchronous reset mid-stream
        run_cycle(0, 0, 0, 0, 32'h5, CSRWI_5, 0, 0);
        run_cycle(0, 0, 0, 0, 32'h7, ADD_X5, 0, 0);
        rst = 1'b1;
        #1;
        check32("rst_inst", wb_inst, NOP);
        check32("rst_we", 32'(wb_we), 32'd0);
        check32("rst_rd", 32'(wb_rd), 32'd0);
        check32("rst_tohost", csr_tohost, 32'h0);
        check32("rst_cycle", cycle_cnt, 32'h0);
        check32("rst_instret", instret_cnt, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) run_cycle(0, 0, 0, 0, 0, NOP, 0, 0);
        check32("post_rst_cycle", cycle_cnt, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
